// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, half-bit start qualification and
// centre-of-bit sampling. Emits a one-cycle pulse per good byte or per framing error.
module uart_rx #(
  parameter int SYS_FREQ = 25000000,
  parameter int BAUDRATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_dat,
  output logic       o_received_pulse,
  output logic       o_frame_error,
  output logic       o_busy
);

  localparam int TICKS = SYS_FREQ / BAUDRATE;
  localparam int HALF  = TICKS / 2;
  localparam logic [15:0] TICKS_M1 = 16'(TICKS - 1);
  localparam logic [15:0] HALF_M1  = 16'(HALF - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  generate
    if (TICKS < 4 || TICKS > 65535) begin : g_bad_ratio
      $error("uart_rx: SYS_FREQ/BAUDRATE must lie in 4..65535");
    end
  endgenerate

  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dat_q, dat_d;
  logic        rx_pulse_q, rx_pulse_d;
  logic        fe_q, fe_d;
  logic        sample;

  // Counter reaching zero marks the centre of the current bit; IDLE and
  // WAIT_HIGH ignore it.
  assign sample = (cnt_q == 16'd0);

  always_comb begin
    rx_meta_d  = i_rx;
    rx_s_d     = rx_meta_q;
    state_d    = state_q;
    cnt_d      = (cnt_q != 16'd0) ? (cnt_q - 16'd1) : cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    dat_d      = dat_q;
    rx_pulse_d = 1'b0;
    fe_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_M1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d     = TICKS_M1;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = TICKS_M1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Leaving mid stop bit lets an immediately following start bit be caught.
        if (sample) begin
          if (rx_s_q) begin
            dat_d      = shift_q;
            rx_pulse_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      dat_q      <= 8'h00;
      rx_pulse_q <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      dat_q      <= dat_d;
      rx_pulse_q <= rx_pulse_d;
      fe_q       <= fe_d;
    end
  end

  assign o_dat            = dat_q;
  assign o_received_pulse = rx_pulse_q;
  assign o_frame_error    = fe_q;
  assign o_busy           = (state_q != ST_IDLE);

endmodule
